// File: rtl/rtc_ad_bus_driver.sv
// Multiplexed address/data bus master: ADDR, GAP1, DATA, GAP2 phases of PHASE_CYC cycles each, then a DONE pulse.
// Latency 4*PHASE_CYC+1 from the start-sampling cycle to done; start is ignored while busy. Reads need macro RTC_BUS_READ_EN.
module rtc_ad_bus_driver #(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(PHASE_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d, ad_out_q, ad_out_d;
  logic       rd_q, rd_d;
  logic       ad_oe_q, ad_oe_d, cs_n_q, cs_n_d, ad_n_q, ad_n_d;
  logic       rd_n_q, rd_n_d, wr_n_q, wr_n_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          cnt_d   = '0;
          addr_d  = addr;
          wdata_d = wdata;
`ifdef RTC_BUS_READ_EN
          rd_d    = rw;
`else
          rd_d    = 1'b0 & rw;  // reads compiled out: every transaction is a write
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          case (state_q)
            S_ADDR:  state_d = S_GAP1;
            S_GAP1:  state_d = S_DATA;
            S_DATA:  state_d = S_GAP2;
            default: state_d = S_DONE;
          endcase
          // device data is taken at the end of the final read-strobe cycle
          if (state_q == S_DATA && rd_q) rdata_d = ad_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    cs_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    case (state_d)
      S_ADDR: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      S_DATA: begin
        cs_n_d = 1'b0;
        if (rd_d) begin
          rd_n_d = 1'b0;
        end else begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      rdata_q  <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      rdata_q  <= rdata_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      cs_n_q   <= cs_n_d;
      ad_n_q   <= ad_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign cs_n   = cs_n_q;
  assign ad_n   = ad_n_q;
  assign rd_n   = rd_n_q;
  assign wr_n   = wr_n_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rtc_ad_bus_driver.sv
// Bench for rtc_ad_bus_driver: PHASE_CYC=4 and PHASE_CYC=2 instances checked every cycle
// against a transaction-timeline model, plus directed scenarios with literal expectations.
module tb_rtc_ad_bus_driver;

`ifdef RTC_BUS_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_i[2], rw_i[2];
  logic [7:0] addr_i[2], wdata_i[2], ad_in_i[2];
  logic [7:0] ad_out_o[2], rdata_o[2];
  logic       ad_oe_o[2], cs_n_o[2], ad_n_o[2], rd_n_o[2], wr_n_o[2], busy_o[2], done_o[2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rtc_ad_bus_driver #(.PHASE_CYC(4)) dut (
    .clk(clk), .reset(reset), .start(start_i[0]), .rw(rw_i[0]),
    .addr(addr_i[0]), .wdata(wdata_i[0]), .ad_in(ad_in_i[0]),
    .ad_out(ad_out_o[0]), .ad_oe(ad_oe_o[0]), .cs_n(cs_n_o[0]), .ad_n(ad_n_o[0]),
    .rd_n(rd_n_o[0]), .wr_n(wr_n_o[0]), .rdata(rdata_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  rtc_ad_bus_driver #(.PHASE_CYC(2)) dut_p2 (
    .clk(clk), .reset(reset), .start(start_i[1]), .rw(rw_i[1]),
    .addr(addr_i[1]), .wdata(wdata_i[1]), .ad_in(ad_in_i[1]),
    .ad_out(ad_out_o[1]), .ad_oe(ad_oe_o[1]), .cs_n(cs_n_o[1]), .ad_n(ad_n_o[1]),
    .rd_n(rd_n_o[1]), .wr_n(wr_n_o[1]), .rdata(rdata_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  function automatic int pc(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, inst, act, exp);
    end
  endtask

  // Model: mk = cycles elapsed since the start-sampling edge (0 = idle, 4P+1 = done cycle).
  int         mk[2];
  logic [7:0] ma[2], mw[2], mrd[2];
  bit         mr[2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mk[i]  <= 0;
        mrd[i] <= 8'h00;
        mr[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mk[i] == 0) begin
          if (start_i[i]) begin
            mk[i] <= 1;
            ma[i] <= addr_i[i];
            mw[i] <= wdata_i[i];
            mr[i] <= READ_EN && rw_i[i];
          end
        end else begin
          if (mk[i] == 3 * pc(i) && mr[i]) mrd[i] <= ad_in_i[i];
          mk[i] <= (mk[i] == 4 * pc(i) + 1) ? 0 : mk[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int p, k, ph;
    bit adr, dat;
    for (int i = 0; i < 2; i++) begin
      p   = pc(i);
      k   = mk[i];
      ph  = (k > 0) ? (k - 1) / p : -1;
      adr = (k > 0) && (k <= 4 * p) && (ph == 0);
      dat = (k > 0) && (k <= 4 * p) && (ph == 2);
      chk(i, "cs_n",  cs_n_o[i],  !(adr || dat));
      chk(i, "ad_n",  ad_n_o[i],  !adr);
      chk(i, "wr_n",  wr_n_o[i],  !(adr || (dat && !mr[i])));
      chk(i, "rd_n",  rd_n_o[i],  !(dat && mr[i]));
      chk(i, "ad_oe", ad_oe_o[i], adr || (dat && !mr[i]));
      chk(i, "busy",  busy_o[i],  k != 0);
      chk(i, "done",  done_o[i],  k == 4 * p + 1);
      chk(i, "rdata", rdata_o[i], mrd[i]);
      if (adr || (dat && !mr[i])) chk(i, "ad_out", ad_out_o[i], adr ? ma[i] : mw[i]);
      chk(i, "strobe_excl", !rd_n_o[i] && !wr_n_o[i], 1'b0);
      chk(i, "oe_in_read",  ad_oe_o[i] && !rd_n_o[i], 1'b0);
    end
  end

  // One transaction; after capture the inputs are scrambled (0x33, inverted rw) to show they are ignored.
  // ad_in carries din only during the DATA window. poke > 0 re-raises start on that cycle.
  task automatic run_txn(input int i, input bit r, input logic [7:0] a, input logic [7:0] w,
                         input logic [7:0] din, input int poke,
                         output int lat, output int na, output int nd, output int nr,
                         output bit saw33, output logic [7:0] rd_done);
    int p;
    p = pc(i);
    na = 0; nd = 0; nr = 0; saw33 = 1'b0; lat = -1; rd_done = 8'h00;
    @(negedge clk);
    #1;
    start_i[i] = 1'b1; rw_i[i] = r; addr_i[i] = a; wdata_i[i] = w; ad_in_i[i] = ~din;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (ad_oe_o[i] && !ad_n_o[i] && !wr_n_o[i] && !cs_n_o[i] && ad_out_o[i] == a) na++;
      if (ad_oe_o[i] && ad_n_o[i] && !wr_n_o[i] && !cs_n_o[i] && ad_out_o[i] == w) nd++;
      if (!rd_n_o[i] && !ad_oe_o[i] && !cs_n_o[i]) nr++;
      if (ad_oe_o[i] && ad_out_o[i] == 8'h33) saw33 = 1'b1;
      if (done_o[i]) begin
        lat = n;
        rd_done = rdata_o[i];
        break;
      end
      #1;
      start_i[i] = (n == poke);
      addr_i[i] = 8'h33; wdata_i[i] = 8'h33; rw_i[i] = ~r;
      ad_in_i[i] = (n >= 2 * p + 1 && n <= 3 * p) ? din : ~din;
    end
    #1;
    start_i[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, na, nd, nr, gap;
    bit s33, found;
    logic [7:0] rdv;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; rw_i[i] = 1'b0; addr_i[i] = 8'h00; wdata_i[i] = 8'h00; ad_in_i[i] = 8'h00;
    end
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk(0, "rst_cs_n", cs_n_o[0], 1'b1);
    chk(0, "rst_rd_n", rd_n_o[0], 1'b1);
    chk(0, "rst_ad_oe", ad_oe_o[0], 1'b0);
    chk(0, "rst_ad_out", ad_out_o[0], 8'h00);
    chk(0, "rst_rdata", rdata_o[0], 8'h00);
    chk(0, "rst_busy", busy_o[0], 1'b0);
    #1 reset = 1'b1;

    // Write 0x59 to 0x21
    run_txn(0, 1'b0, 8'h21, 8'h59, 8'h00, 0, lat, na, nd, nr, s33, rdv);
    chk(0, "wr_latency", lat, 17);
    chk(0, "wr_addr_cycles", na, 4);
    chk(0, "wr_data_cycles", nd, 4);
    chk(0, "wr_rd_cycles", nr, 0);

`ifdef RTC_BUS_READ_EN
    run_txn(0, 1'b1, 8'h22, 8'h9C, 8'hA7, 0, lat, na, nd, nr, s33, rdv);
    chk(0, "rd_latency", lat, 17);
    chk(0, "rd_strobe_cycles", nr, 4);
    chk(0, "rd_rdata", rdv, 8'hA7);
    run_txn(0, 1'b0, 8'h70, 8'h71, 8'h00, 0, lat, na, nd, nr, s33, rdv);
    chk(0, "wr_keeps_rdata", rdv, 8'hA7);
`else
    run_txn(0, 1'b1, 8'h05, 8'h9C, 8'hA7, 0, lat, na, nd, nr, s33, rdv);
    chk(0, "rwoff_latency", lat, 17);
    chk(0, "rwoff_write_cycles", nd, 4);
    chk(0, "rwoff_rd_cycles", nr, 0);
    chk(0, "rwoff_rdata", rdv, 8'h00);
`endif

    // start re-pulsed mid-transaction with 0x33 on addr/wdata
    run_txn(0, 1'b0, 8'h40, 8'h41, 8'h00, 5, lat, na, nd, nr, s33, rdv);
    chk(0, "busy_latency", lat, 17);
    chk(0, "busy_saw_33", s33, 1'b0);
    @(negedge clk);
    chk(0, "busy_after_done", busy_o[0], 1'b0);
    @(negedge clk);
    chk(0, "busy_no_relaunch", busy_o[0], 1'b0);

    // start held high: back-to-back with one idle cycle between
    #1;
    start_i[0] = 1'b1; rw_i[0] = 1'b0; addr_i[0] = 8'h50; wdata_i[0] = 8'h51;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      found = done_o[0];
    end
    chk(0, "b2b_first_done", found, 1'b1);
    gap = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (busy_o[0]) break;
      gap++;
    end
    chk(0, "b2b_idle_gap", gap, 1);
    chk(0, "b2b_second_addr", ad_out_o[0], 8'h50);
    #1 start_i[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      found = done_o[0];
    end
    chk(0, "b2b_second_done", found, 1'b1);

    // reset during the DATA phase of a write
    @(negedge clk);
    #1;
    start_i[0] = 1'b1; rw_i[0] = 1'b0; addr_i[0] = 8'h60; wdata_i[0] = 8'h61;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      #1 start_i[0] = 1'b0;
    end
    chk(0, "rstmid_in_data", wr_n_o[0], 1'b0);
    reset = 1'b0;
    #1;
    chk(0, "rstmid_wr_n", wr_n_o[0], 1'b1);
    chk(0, "rstmid_cs_n", cs_n_o[0], 1'b1);
    chk(0, "rstmid_ad_oe", ad_oe_o[0], 1'b0);
    chk(0, "rstmid_busy", busy_o[0], 1'b0);
    found = 1'b0;
    repeat (2) begin
      @(negedge clk);
      found = found | done_o[0];
    end
    #1 reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      found = found | done_o[0];
    end
    chk(0, "rstmid_no_done", found, 1'b0);
    run_txn(0, 1'b1, 8'h10, 8'h77, 8'h3C, 0, lat, na, nd, nr, s33, rdv);
    chk(0, "post_rst_latency", lat, 17);
    chk(0, "post_rst_addr_cycles", na, 4);
`ifdef RTC_BUS_READ_EN
    chk(0, "post_rst_rdata", rdv, 8'h3C);
`else
    chk(0, "post_rst_rdata", rdv, 8'h00);
`endif

    // PHASE_CYC = 2 instance
    run_txn(1, 1'b0, 8'h12, 8'h34, 8'h00, 0, lat, na, nd, nr, s33, rdv);
    chk(1, "p2_latency", lat, 9);
    chk(1, "p2_addr_cycles", na, 2);
    chk(1, "p2_data_cycles", nd, 2);
`ifdef RTC_BUS_READ_EN
    run_txn(1, 1'b1, 8'h56, 8'h00, 8'hC3, 0, lat, na, nd, nr, s33, rdv);
    chk(1, "p2_rd_cycles", nr, 2);
    chk(1, "p2_rdata", rdv, 8'hC3);
`else
    run_txn(1, 1'b1, 8'h56, 8'h9A, 8'hC3, 0, lat, na, nd, nr, s33, rdv);
    chk(1, "p2_rwoff_rd_cycles", nr, 0);
    chk(1, "p2_rwoff_rdata", rdv, 8'h00);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
